// File: rtl/delay_timer_scheduler_if.sv
// -----------------------------------------------------------------------------
// delay_timer_scheduler_if
//
// Purpose: groups the requester-side handshake and the shared time-base
// strobe of the delay timer scheduler into one bundle.
//
// Signals:
//   tick_en      time-base strobe, the delay counter only moves when high
//   req          per-channel level request, held until grant is seen
//   wb_flat      channel i delay length at bits [i*WB_W +: WB_W]
//   abort        per-channel cancel, honoured only for the active channel
//   grant        one-cycle one-hot pulse when a channel is loaded
//   done         one-cycle one-hot pulse when a delay completes
//   delay_out_n  active-low, channel i low while its delay runs
//   busy         high while a channel is being served
//   active_ch    index of the loaded channel, holds last value when idle
//
// Modports:
//   master  requester / control side (drives req, wb_flat, abort, tick_en)
//   slave   scheduler side (drives grant, done, delay_out_n, busy, active_ch)
// -----------------------------------------------------------------------------
interface delay_timer_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int WB_W   = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   tick_en;
    logic [NUM_CH-1:0]      req;
    logic [NUM_CH*WB_W-1:0] wb_flat;
    logic [NUM_CH-1:0]      abort;
    logic [NUM_CH-1:0]      grant;
    logic [NUM_CH-1:0]      done;
    logic [NUM_CH-1:0]      delay_out_n;
    logic                   busy;
    logic [CH_W-1:0]        active_ch;

    modport master (
        output tick_en,
        output req,
        output wb_flat,
        output abort,
        input  grant,
        input  done,
        input  delay_out_n,
        input  busy,
        input  active_ch
    );

    modport slave (
        input  tick_en,
        input  req,
        input  wb_flat,
        input  abort,
        output grant,
        output done,
        output delay_out_n,
        output busy,
        output active_ch
    );
endinterface

// File: rtl/delay_timer_scheduler.sv
// -----------------------------------------------------------------------------
// delay_timer_scheduler
//
// Purpose: shares one delay counter between NUM_CH requesters. Requests are
// served one at a time in round-robin order; the served channel's active-low
// output is held low for its programmed number of time-base ticks, after
// which its done flag pulses for one cycle.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset_n   asynchronous active-low reset
//   bus       delay_timer_scheduler_if.slave (tick_en, req, wb_flat, abort in;
//             grant, done, delay_out_n, busy, active_ch out)
//
// Parameters:
//   NUM_CH    number of requesting channels (2..16)
//   WB_W      width of each channel's delay value (ticks)
//
// Build option:
//   DTS_RETRIGGER_EN  when defined, a rising edge of req on the active channel
//                     while its delay runs reloads the counter with the
//                     channel's current delay value (retriggerable one-shot).
//                     When undefined, req of the active channel is ignored
//                     while its delay runs.
//
// FSM: IDLE -> (grant) -> RUN -> DONE -> IDLE. A zero-length delay skips RUN.
// All outputs are registered and updated by the single FSM process.
// -----------------------------------------------------------------------------
module delay_timer_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WB_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    delay_timer_scheduler_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [WB_W-1:0]   CNT_ZERO = {WB_W{1'b0}};
    localparam logic [WB_W-1:0]   CNT_ONE  = {{(WB_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_CH-1:0] CH_NONE  = {NUM_CH{1'b0}};
    localparam logic [NUM_CH-1:0] CH_ALL   = {NUM_CH{1'b1}};
    localparam logic [CH_W-1:0]   IDX_ZERO = {CH_W{1'b0}};
    // Pointer starts at the last channel so channel 0 wins the first scan.
    localparam logic [CH_W-1:0]   IDX_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [WB_W-1:0]     count_r;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [CH_W-1:0]     active_ch_r;
    logic [NUM_CH-1:0]   grant_r;
    logic [NUM_CH-1:0]   done_r;
    logic [NUM_CH-1:0]   delay_out_n_r;
    logic                busy_r;

    logic [CH_W-1:0]     sel_s;
    logic                found_s;
    logic [WB_W-1:0]     wb_sel_s;
    logic                abort_act_s;
    logic                retrig_s;

`ifdef DTS_RETRIGGER_EN
    logic [NUM_CH-1:0]   req_q_r;
    logic [WB_W-1:0]     wb_act_s;
`endif

    // One-hot vector with only bit idx set.
    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = {NUM_CH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first requesting channel after rr_ptr, wrapping around.
    always_comb begin
        sel_s   = IDX_ZERO;
        found_s = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            int  idx;
            logic hit;
            idx     = (int'(rr_ptr_r) + i) % NUM_CH;
            hit     = !found_s && bus.req[idx];
            sel_s   = hit ? CH_W'(idx) : sel_s;
            found_s = found_s | hit;
        end
        wb_sel_s    = bus.wb_flat[int'(sel_s)*WB_W +: WB_W];
        abort_act_s = bus.abort[active_ch_r];
    end

`ifdef DTS_RETRIGGER_EN
    // Rising edge of the active channel's request restarts its delay.
    always_comb begin
        wb_act_s = bus.wb_flat[int'(active_ch_r)*WB_W +: WB_W];
        retrig_s = bus.req[active_ch_r] & ~req_q_r[active_ch_r];
    end

    // Registered copy of req used for the retrigger edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q_r <= CH_NONE;
        end else begin
            // The held request that produced the grant is already captured
            // here, so it is not mistaken for a retrigger edge.
            req_q_r <= bus.req;
        end
    end
`else
    // Retriggering is not built in; the active channel's req is ignored.
    always_comb begin
        retrig_s = 1'b0;
    end
`endif

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            count_r       <= CNT_ZERO;
            rr_ptr_r      <= IDX_LAST;
            active_ch_r   <= IDX_ZERO;
            grant_r       <= CH_NONE;
            done_r        <= CH_NONE;
            delay_out_n_r <= CH_ALL;
            busy_r        <= 1'b0;
        end else begin
            // grant and done are single-cycle pulses.
            grant_r <= CH_NONE;
            done_r  <= CH_NONE;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        active_ch_r   <= sel_s;
                        count_r       <= wb_sel_s;
                        grant_r       <= onehot(sel_s);
                        delay_out_n_r <= ~onehot(sel_s);
                        busy_r        <= 1'b1;
                        // A zero-length delay goes straight to completion.
                        state_r       <= (wb_sel_s == CNT_ZERO) ? ST_DONE : ST_RUN;
                    end else begin
                        delay_out_n_r <= CH_ALL;
                        busy_r        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort_act_s) begin
                        // Abort wins over a same-cycle expiry; no done pulse.
                        delay_out_n_r <= CH_ALL;
                        rr_ptr_r      <= active_ch_r;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else if (retrig_s) begin
`ifdef DTS_RETRIGGER_EN
                        count_r <= wb_act_s;
`else
                        count_r <= count_r;
`endif
                    end else if (bus.tick_en) begin
                        // count <= 1 also covers a retrigger reload of zero.
                        if (count_r <= CNT_ONE) begin
                            count_r <= CNT_ZERO;
                            state_r <= ST_DONE;
                        end else begin
                            count_r <= count_r - CNT_ONE;
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_DONE: begin
                    done_r        <= onehot(active_ch_r);
                    delay_out_n_r <= CH_ALL;
                    rr_ptr_r      <= active_ch_r;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    delay_out_n_r <= CH_ALL;
                    busy_r        <= 1'b0;
                    count_r       <= CNT_ZERO;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.done        = done_r;
    assign bus.delay_out_n = delay_out_n_r;
    assign bus.busy        = busy_r;
    assign bus.active_ch   = active_ch_r;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_scheduler
//
// Self-checking bench for delay_timer_scheduler (NUM_CH=4, WB_W=8): a table of
// per-cycle vectors, hand-written corner-case sequences, and a randomized run
// compared every cycle against a tick-counting reference model.
// -----------------------------------------------------------------------------
module tb_delay_timer_scheduler;
    localparam int NCH = 4;
    localparam int WBW = 8;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    delay_timer_scheduler_if #(.NUM_CH(NCH), .WB_W(WBW)) bus ();

    delay_timer_scheduler #(.NUM_CH(NCH), .WB_W(WBW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the bench must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Phase: 0 = nobody served, 1 = counting ticks, 2 = completing.
    int         m_phase, m_ch, m_target, m_seen, m_last;
    logic [3:0] m_req_prev;
    logic [3:0] e_grant, e_done, e_dly;
    logic       e_busy;
    logic [1:0] e_act;

    function automatic int wb_of(input int ch);
        logic [31:0] w;
        w = bus.wb_flat;
        return int'(w[ch*WBW +: WBW]);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ch = 0; m_target = 0; m_seen = 0; m_last = NCH - 1;
        m_req_prev = 4'b0000;
        e_grant = 4'b0000; e_done = 4'b0000; e_dly = 4'b1111;
        e_busy = 1'b0; e_act = 2'd0;
    endtask

    // Predict outputs after the next rising edge from the inputs now applied.
    task automatic model_edge();
        int         pick;
        logic [3:0] r;
        r       = bus.req;
        e_grant = 4'b0000;
        e_done  = 4'b0000;
        if (m_phase == 0) begin
            pick = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (pick < 0 && r[c]) pick = c;
            end
            if (pick >= 0) begin
                m_ch = pick; m_target = wb_of(pick); m_seen = 0;
                e_grant[pick] = 1'b1;
                e_dly = 4'b1111; e_dly[pick] = 1'b0;
                e_busy = 1'b1; e_act = 2'(pick);
                m_phase = (m_target == 0) ? 2 : 1;
            end else begin
                e_dly = 4'b1111; e_busy = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (bus.abort[m_ch]) begin
                m_phase = 0; m_last = m_ch; e_dly = 4'b1111; e_busy = 1'b0;
            end
`ifdef DTS_RETRIGGER_EN
            else if (r[m_ch] && !m_req_prev[m_ch]) begin
                m_target = wb_of(m_ch); m_seen = 0;
            end
`endif
            else if (bus.tick_en) begin
                m_seen++;
                if (m_seen >= m_target) m_phase = 2;
            end
        end else begin
            e_done[m_ch] = 1'b1; e_dly = 4'b1111; e_busy = 1'b0;
            m_last = m_ch; m_phase = 0;
        end
        m_req_prev = r;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] n, input logic b, input logic [1:0] a);
        chk({tag, ".grant"},       32'(bus.grant),       32'(g));
        chk({tag, ".done"},        32'(bus.done),        32'(d));
        chk({tag, ".delay_out_n"}, 32'(bus.delay_out_n), 32'(n));
        chk({tag, ".busy"},        32'(bus.busy),        32'(b));
        chk({tag, ".active_ch"},   32'(bus.active_ch),   32'(a));
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, e_grant, e_done, e_dly, e_busy, e_act);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = 4'b0000; bus.abort = 4'b0000; bus.tick_en = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [3:0] abort;
        logic       tick;
        logic [3:0] x_grant;
        logic [3:0] x_done;
        logic [3:0] x_dly;
        logic       x_busy;
        logic [1:0] x_act;
    } vec_t;

    vec_t vec [10];

    int         gap_q [$];
    int         order_q [$];
    int         last_g, cyc, dcount, lowcnt;

    initial begin
        // ch0=3, ch1=5, ch2=0, ch3=10
        vec[0] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[1] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[2] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[4] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1101, 1'b1, 2'd1};
        vec[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b1111, 1'b0, 2'd1};
        vec[7] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b1011, 1'b1, 2'd2};
        vec[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 4'b1111, 1'b0, 2'd2};
        vec[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd2};

        checks = 0; failures = 0;
        bus.wb_flat = 32'h0A00_0503;
        do_reset();
        chk_out("reset", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0);

        // Single channel (wb=5) then zero-length delay on channel 2.
        for (int i = 0; i < 10; i++) begin
            bus.req = vec[i].req; bus.abort = vec[i].abort; bus.tick_en = vec[i].tick;
            step();
            chk_out($sformatf("vec%0d", i), vec[i].x_grant, vec[i].x_done,
                    vec[i].x_dly, vec[i].x_busy, vec[i].x_act);
        end

        // Round-robin: all requests held, every delay 2 ticks.
        do_reset();
        bus.wb_flat = 32'h0202_0202; bus.req = 4'b1111; bus.tick_en = 1'b1;
        last_g = -1; cyc = 0;
        while (order_q.size() < 5 && cyc < 60) begin
            step(); cyc++;
            chk_model("rr");
            for (int c = 0; c < NCH; c++) begin
                if (bus.grant[c]) begin
                    order_q.push_back(c);
                    if (last_g >= 0) gap_q.push_back(cyc - last_g);
                    last_g = cyc;
                end
            end
        end
        bus.req = 4'b0000;
        chk("rr.grant_count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < order_q.size(); i++)
            chk($sformatf("rr.order%0d", i), 32'(order_q[i]), 32'(i % NCH));
        // grant, two ticks, done cycle with one idle cycle, next grant
        for (int i = 0; i < gap_q.size(); i++)
            chk($sformatf("rr.spacing%0d", i), 32'(gap_q[i]), 32'd4);

        // Time base: tick every 4th cycle, wb[0]=3.
        do_reset();
        bus.wb_flat = 32'h0000_0003; dcount = 0; lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            bus.req = (i == 0) ? 4'b0001 : 4'b0000;
            bus.tick_en = ((i % 4) == 3);
            step();
            chk_model("tbase");
            if (bus.done[0]) dcount++;
            if (!bus.delay_out_n[0]) lowcnt++;
        end
        chk("tbase.done_count", 32'(dcount), 32'd1);
        // grant at edge 1, ticks at edges 4, 8, 12, done state until edge 13
        chk("tbase.low_cycles", 32'(lowcnt), 32'd12);

        // Abort on the active channel; abort on another channel ignored.
        do_reset();
        bus.wb_flat = 32'h0A00_0000; bus.tick_en = 1'b1;
        bus.req = 4'b1000; step(); chk_model("abort.grant");
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.abort = (i == 1) ? 4'b0001 : 4'b0000;
            step(); chk_model("abort.run");
        end
        chk("abort.still_low", 32'(bus.delay_out_n), 32'h7);
        bus.abort = 4'b1001; step(); chk_model("abort.hit");
        chk("abort.released", 32'(bus.delay_out_n), 32'hF);
        bus.abort = 4'b0000; dcount = 0;
        for (int i = 0; i < 15; i++) begin
            step(); chk_model("abort.after");
            if (bus.done != 4'b0000) dcount++;
        end
        chk("abort.no_done", 32'(dcount), 32'd0);

        // Asynchronous reset in the middle of a running delay.
        bus.wb_flat = 32'h0000_0500;
        bus.req = 4'b0010; step(); bus.req = 4'b0000; step(); step();
        chk("areset.pre_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #2;
        chk_out("areset", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;

`ifdef DTS_RETRIGGER_EN
        // Retrigger: wb[1]=6, re-pulse req[1] after 4 ticks.
        do_reset();
        bus.wb_flat = 32'h0000_0600; bus.tick_en = 1'b1; dcount = 0; lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req = (i == 0 || i == 5) ? 4'b0010 : 4'b0000;
            step(); chk_model("retrig");
            if (bus.grant[1]) dcount++;
            if (!bus.delay_out_n[1]) lowcnt++;
        end
        chk("retrig.grants", 32'(dcount), 32'd1);
        // grant cycle + 4 ticks + reload cycle + 6 ticks
        chk("retrig.low_cycles", 32'(lowcnt), 32'd12);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        bus.wb_flat = 32'h0302_0104;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                for (int c = 0; c < NCH; c++)
                    bus.wb_flat[c*WBW +: WBW] = 8'($urandom_range(0, 6));
            bus.req     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            bus.abort   = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0000;
            bus.tick_en = ($urandom_range(0, 3) != 0);
            step();
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
